// File: rtl/video_stream_pkg.sv
// Shared FSM state type, default timing constants and width helpers
// for the test-pattern video stream generator.
package video_stream_pkg;

   typedef enum logic [2:0] {
      IDLE,
      VFRONT,
      ACTIVE,
      HGAP,
      VBACK,
      VBLANK
   } state_t;

   localparam int DEF_DW      = 8;
   localparam int DEF_IW      = 4;
   localparam int DEF_IH      = 4;
   localparam int DEF_H_TOTAL = 8;
   localparam int DEF_V_FRONT = 6;
   localparam int DEF_V_BACK  = 2;
   localparam int DEF_V_BLANK = 30;

   // A counter for n states needs clog2(n) bits, never fewer than one.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/vs_counter.sv
// Up-counter with synchronous load, count enable and a terminal-count
// flag that asserts while the count equals the supplied limit.
module vs_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         inc,
   input  logic [W-1:0] load_val,
   input  logic [W-1:0] limit,
   output logic         tc
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count == limit);

endmodule

// File: rtl/video_stream_gen.sv
// Frame/line timing generator emitting a ramp or constant test pattern
// with registered vsync/hsync/pixel outputs and an end-of-frame pulse.
module video_stream_gen
   import video_stream_pkg::*;
#(
   parameter int DW      = DEF_DW,
   parameter int IW      = DEF_IW,
   parameter int IH      = DEF_IH,
   parameter int H_TOTAL = DEF_H_TOTAL,
   parameter int V_FRONT = DEF_V_FRONT,
   parameter int V_BACK  = DEF_V_BACK,
   parameter int V_BLANK = DEF_V_BLANK
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          mode,
   input  logic [DW-1:0] pat_const,
   output logic          dout_vsync,
   output logic          dout_hsync,
   output logic [DW-1:0] dout,
   output logic          frame_done
);

   localparam int XW = cnt_w(IW);
   localparam int YW = cnt_w(IH);
   localparam int HW = cnt_w(H_TOTAL);
   localparam int PW = cnt_w(max3(V_FRONT, V_BACK, V_BLANK));

   localparam logic [XW-1:0] X_LAST   = XW'(IW - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(IH - 1);
   localparam logic [HW-1:0] GAP_LAST = HW'(H_TOTAL - IW - 1);
   localparam logic [PW-1:0] VF_LAST  = PW'(V_FRONT - 1);
   localparam logic [PW-1:0] VB_LAST  = PW'(V_BACK - 1);
   localparam logic [PW-1:0] VK_LAST  = PW'(V_BLANK - 1);

   state_t          state;
   logic            mode_q;
   logic [DW-1:0]   const_q;
   logic [DW-1:0]   ramp;
   logic [DW-1:0]   pixel;

   logic            pix_load, pix_inc, pix_tc;
   logic            line_load, line_inc, line_tc;
   logic            gap_load, gap_inc, gap_tc;
   logic            ph_load, ph_inc, ph_tc, ph_in_v;
   logic [PW-1:0]   ph_limit;

   // The ramp runs once per active pixel across the whole frame, so it
   // equals y*IW + x and wraps modulo 2^DW on its own.
   assign pixel = mode_q ? const_q : ramp;

   always_comb begin
      pix_load  = (state != ACTIVE) || pix_tc;
      pix_inc   = (state == ACTIVE);
      line_load = (state != ACTIVE) && (state != HGAP);
      line_inc  = (state == ACTIVE) && pix_tc;
      gap_load  = (state != HGAP) || gap_tc;
      gap_inc   = (state == HGAP);
      ph_in_v   = (state == VFRONT) || (state == VBACK) || (state == VBLANK);
      ph_load   = !ph_in_v || ph_tc;
      ph_inc    = ph_in_v;
      ph_limit  = '0;
      case (state)
         VFRONT:  ph_limit = VF_LAST;
         VBACK:   ph_limit = VB_LAST;
         VBLANK:  ph_limit = VK_LAST;
         default: ph_limit = '0;
      endcase
   end

   vs_counter #(.W(XW)) u_pix (
      .clk(clk), .rst(rst), .load(pix_load), .inc(pix_inc),
      .load_val('0), .limit(X_LAST), .tc(pix_tc)
   );

   vs_counter #(.W(YW)) u_line (
      .clk(clk), .rst(rst), .load(line_load), .inc(line_inc),
      .load_val('0), .limit(Y_LAST), .tc(line_tc)
   );

   vs_counter #(.W(HW)) u_gap (
      .clk(clk), .rst(rst), .load(gap_load), .inc(gap_inc),
      .load_val('0), .limit(GAP_LAST), .tc(gap_tc)
   );

   vs_counter #(.W(PW)) u_phase (
      .clk(clk), .rst(rst), .load(ph_load), .inc(ph_inc),
      .load_val('0), .limit(ph_limit), .tc(ph_tc)
   );

   // Outputs are set on the same edge as the state they belong to, so
   // the registered outputs always describe the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         dout_vsync <= 1'b0;
         dout_hsync <= 1'b0;
         dout       <= '0;
         frame_done <= 1'b0;
         mode_q     <= 1'b0;
         const_q    <= '0;
         ramp       <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (en) begin
                  state      <= VFRONT;
                  dout_vsync <= 1'b1;
                  mode_q     <= mode;
                  const_q    <= pat_const;
                  ramp       <= '0;
               end
            end
            VFRONT: begin
               if (ph_tc) begin
                  state      <= ACTIVE;
                  dout_hsync <= 1'b1;
                  dout       <= pixel;
                  ramp       <= ramp + 1'b1;
               end
            end
            ACTIVE: begin
               if (pix_tc) begin
                  dout_hsync <= 1'b0;
                  dout       <= '0;
                  state      <= line_tc ? VBACK : HGAP;
               end else begin
                  dout <= pixel;
                  ramp <= ramp + 1'b1;
               end
            end
            HGAP: begin
               if (gap_tc) begin
                  state      <= ACTIVE;
                  dout_hsync <= 1'b1;
                  dout       <= pixel;
                  ramp       <= ramp + 1'b1;
               end
            end
            VBACK: begin
               if (ph_tc) begin
                  state      <= VBLANK;
                  dout_vsync <= 1'b0;
                  frame_done <= 1'b1;
               end
            end
            VBLANK: begin
               if (ph_tc) begin
                  if (en) begin
                     state      <= VFRONT;
                     dout_vsync <= 1'b1;
                     mode_q     <= mode;
                     const_q    <= pat_const;
                     ramp       <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_video_stream_gen.sv
// Directed bench for video_stream_gen: timing checked per cycle, pixel
// values checked through per-instance expected-pixel queues.
module tb_video_stream_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       en_a, mode_a;
   logic [7:0] pat_a;
   logic       vs_a, hs_a, fd_a;
   logic [7:0] d_a;
   logic       en_b, mode_b;
   logic [3:0] pat_b;
   logic       vs_b, hs_b, fd_b;
   logic [3:0] d_b;

   int         errors = 0;
   int         checks = 0;
   bit         mon_on = 1'b0;
   logic [7:0] qa[$];
   logic [3:0] qb[$];

   always #5 clk = ~clk;

   video_stream_gen dut_a (
      .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .pat_const(pat_a),
      .dout_vsync(vs_a), .dout_hsync(hs_a), .dout(d_a), .frame_done(fd_a)
   );

   video_stream_gen #(.DW(4), .IW(8), .IH(4), .H_TOTAL(12)) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .pat_const(pat_b),
      .dout_vsync(vs_b), .dout_hsync(hs_b), .dout(d_b), .frame_done(fd_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Default-timing frame, r = samples since the en-sampling edge (1-based).
   function automatic bit f_vs(input int r);
      return (r >= 1) && (r <= 36);
   endfunction
   function automatic bit f_hs(input int r);
      return (r >= 7) && (r <= 34) && (((r - 7) % 8) < 4);
   endfunction
   function automatic bit f_fd(input int r);
      return r == 37;
   endfunction

   task automatic chk_a(input string tag, input bit vs, input bit hs, input bit fd);
      chk({tag, "_vsync"}, 32'(vs_a), 32'(vs));
      chk({tag, "_hsync"}, 32'(hs_a), 32'(hs));
      chk({tag, "_frame_done"}, 32'(fd_a), 32'(fd));
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         if (hs_a === 1'b1) begin
            chk("a_pixel_expected", 32'(qa.size() > 0), 32'd1);
            if (qa.size() > 0) chk("a_pixel", 32'(d_a), 32'(qa.pop_front()));
         end else begin
            chk("a_blank_dout", 32'(d_a), 32'd0);
         end
         if (hs_b === 1'b1) begin
            chk("b_pixel_expected", 32'(qb.size() > 0), 32'd1);
            if (qb.size() > 0) chk("b_pixel", 32'(d_b), 32'(qb.pop_front()));
         end else begin
            chk("b_blank_dout", 32'(d_b), 32'd0);
         end
      end
   end

   initial begin
      rst = 1'b1;
      en_a = 1'b0; mode_a = 1'b0; pat_a = 8'h00;
      en_b = 1'b0; mode_b = 1'b0; pat_b = 4'h0;
      tick(); tick();
      chk_a("reset", 1'b0, 1'b0, 1'b0);
      chk("reset_dout", 32'(d_a), 32'd0);
      chk("reset_b_vsync", 32'(vs_b), 32'd0);
      rst = 1'b0;
      mon_on = 1'b1;
      for (int s = 1; s <= 5; s++) begin
         tick();
         chk_a("idle_no_en", 1'b0, 1'b0, 1'b0);
      end

      // Two back-to-back ramp frames, en dropped mid second frame.
      mode_a = 1'b0; en_a = 1'b1;
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < 16; i++) qa.push_back(8'(i));
      for (int s = 1; s <= 152; s++) begin
         tick();
         chk_a("ramp_frames", f_vs(s) || f_vs(s - 66), f_hs(s) || f_hs(s - 66),
               f_fd(s) || f_fd(s - 66));
         if (s == 86) en_a = 1'b0;
      end
      chk("ramp_frames_drained", 32'(qa.size()), 32'd0);

      // Reset mid-line of the second active line.
      en_a = 1'b1;
      for (int i = 0; i < 6; i++) qa.push_back(8'(i));
      for (int s = 1; s <= 16; s++) begin
         tick();
         chk_a("pre_reset", f_vs(s), f_hs(s), 1'b0);
      end
      rst = 1'b1; en_a = 1'b0;
      tick();
      chk_a("mid_reset", 1'b0, 1'b0, 1'b0);
      chk("mid_reset_dout", 32'(d_a), 32'd0);
      rst = 1'b0;
      for (int s = 1; s <= 40; s++) begin
         tick();
         chk_a("post_reset_idle", 1'b0, 1'b0, 1'b0);
      end
      chk("reset_drained", 32'(qa.size()), 32'd0);

      // Constant pattern; mode/pat_const changed mid-frame must not matter.
      mode_a = 1'b1; pat_a = 8'hA5; en_a = 1'b1;
      for (int i = 0; i < 16; i++) qa.push_back(8'hA5);
      for (int s = 1; s <= 70; s++) begin
         tick();
         if (s == 1) en_a = 1'b0;
         if (s == 12) begin mode_a = 1'b0; pat_a = 8'h3C; end
         chk_a("const_frame", f_vs(s), f_hs(s), f_fd(s));
      end
      chk("const_drained", 32'(qa.size()), 32'd0);

      // Next frame picks up the new mode (ramp).
      en_a = 1'b1;
      for (int i = 0; i < 16; i++) qa.push_back(8'(i));
      for (int s = 1; s <= 70; s++) begin
         tick();
         if (s == 1) en_a = 1'b0;
         chk_a("mode_next_frame", f_vs(s), f_hs(s), f_fd(s));
      end
      chk("mode_next_drained", 32'(qa.size()), 32'd0);

      // 4-bit, 8-wide instance: ramp wraps 15 -> 0 at line 2 pixel 0.
      mode_b = 1'b0; en_b = 1'b1;
      for (int i = 0; i < 32; i++) qb.push_back(4'(i));
      for (int s = 1; s <= 60; s++) begin
         tick();
         if (s == 1) en_b = 1'b0;
         chk("b_vsync", 32'(vs_b), 32'((s >= 1) && (s <= 52)));
         chk("b_hsync", 32'(hs_b), 32'((s >= 7) && (s <= 50) && (((s - 7) % 12) < 8)));
         chk("b_frame_done", 32'(fd_b), 32'(s == 53));
         if (s == 26) chk("b_line1_last", 32'(d_b), 32'd15);
         if (s == 31) chk("b_wrap_line2_px0", 32'(d_b), 32'd0);
      end
      chk("b_drained", 32'(qb.size()), 32'd0);

      mon_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
